// File: rtl/reset_release_sequencer.sv
// rtl/reset_release_sequencer.sv - stretches reset requests and releases N domains in index order
// Optional ack-phase timeout is compiled in with RSTSEQ_ACK_TIMEOUT_EN.
module reset_release_sequencer #(
    parameter int N_DOM       = 3,
    parameter int MIN_ASSERT  = 8,
    parameter int REL_GAP     = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_rst_req,
    input  logic             wdt_rst_req,
    input  logic [N_DOM-1:0] dom_in_rst,
    output logic [N_DOM-1:0] rst_req_out,
    output logic             busy,
    output logic [1:0]       rst_cause,
    output logic             timeout_err
);

    localparam int MAX_AG = (MIN_ASSERT > REL_GAP) ? MIN_ASSERT : REL_GAP;
    localparam int MAX_C  = (MAX_AG > ACK_TIMEOUT) ? MAX_AG : ACK_TIMEOUT;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam int IW     = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [CW-1:0] ASSERT_LAST = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] GAP_LAST    = (REL_GAP > 0) ? CW'(REL_GAP - 1) : '0;
    localparam logic [IW-1:0] LAST_DOM    = IW'(N_DOM - 1);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_ALL,
        ST_REL,
        ST_GAP,
        ST_RUN
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic [N_DOM-1:0] rst_req_q;
    logic             busy_q;
    logic [1:0]       cause_q;

    logic             req;
    logic             ack_to;
    logic [IW-1:0]    idx_d;

    assign req   = sw_rst_req | wdt_rst_req;
    assign idx_d = idx_q + 1'b1;

`ifdef RSTSEQ_ACK_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

    logic err_q;
    logic ack_ok;

    assign ack_ok = (state_q == ST_WAIT_ALL) ? (&dom_in_rst) : ~dom_in_rst[idx_q];
    assign ack_to = ((state_q == ST_WAIT_ALL) || (state_q == ST_REL)) && (cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (ack_to && !ack_ok) begin
            err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    assign ack_to      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_req_q <= '1;
            busy_q    <= 1'b1;
            cause_q   <= 2'b00;
        end else if (req) begin
            // Any request, in any state, restarts the whole sequence.
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_req_q <= '1;
            busy_q    <= 1'b1;
            cause_q   <= wdt_rst_req ? 2'b10 : 2'b01;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == ASSERT_LAST) begin
                        state_q <= ST_WAIT_ALL;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_ALL: begin
                    if ((&dom_in_rst) || ack_to) begin
                        state_q      <= ST_REL;
                        cnt_q        <= '0;
                        idx_q        <= '0;
                        rst_req_q[0] <= 1'b0;
                    end
`ifdef RSTSEQ_ACK_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ST_REL: begin
                    if (!dom_in_rst[idx_q] || ack_to) begin
                        cnt_q <= '0;
                        if (REL_GAP != 0) begin
                            state_q <= ST_GAP;
                        end else if (idx_q == LAST_DOM) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q            <= idx_d;
                            rst_req_q[idx_d] <= 1'b0;
                        end
                    end
`ifdef RSTSEQ_ACK_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == LAST_DOM) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q          <= ST_REL;
                            idx_q            <= idx_d;
                            rst_req_q[idx_d] <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rst_req_q <= '0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q   <= ST_ASSERT;
                    cnt_q     <= '0;
                    rst_req_q <= '1;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign rst_req_out = rst_req_q;
    assign busy        = busy_q;
    assign rst_cause   = cause_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb/tb_reset_release_sequencer.sv - directed bench with a 2-cycle domain ack model
module tb_reset_release_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       wdt_rst_req = 1'b0;
    logic [2:0] dom_in_rst;
    logic [2:0] rst_req_out;
    logic       busy;
    logic [1:0] rst_cause;
    logic       timeout_err;

    logic [2:0] d1 = 3'b111;
    logic [2:0] d2 = 3'b111;
    logic [2:0] stuck = 3'b000;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Each domain reports its synchronized reset two edges after the request changes.
    always @(posedge clk) begin
        d1 <= rst_req_out;
        d2 <= d1;
    end
    assign dom_in_rst = d2 | stuck;

    reset_release_sequencer #(
        .N_DOM(3), .MIN_ASSERT(8), .REL_GAP(4), .ACK_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_rst_req(sw_rst_req),
        .wdt_rst_req(wdt_rst_req),
        .dom_in_rst(dom_in_rst),
        .rst_req_out(rst_req_out),
        .busy(busy),
        .rst_cause(rst_cause),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic sw, input logic wdt);
        sw_rst_req  = sw;
        wdt_rst_req = wdt;
        step(1);
        sw_rst_req  = 1'b0;
        wdt_rst_req = 1'b0;
    endtask

    initial begin
        // POR
        step(3);
        check("por_out", 32'(rst_req_out), 32'h7);
        check("por_busy", 32'(busy), 32'h1);
        check("por_cause", 32'(rst_cause), 32'h0);
        check("por_err", 32'(timeout_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(8);
        check("por_hold8", 32'(rst_req_out), 32'h7);
        step(1);
        check("por_rel0", 32'(rst_req_out), 32'h6);
        step(6);
        check("por_gap0", 32'(rst_req_out), 32'h6);
        step(1);
        check("por_rel1", 32'(rst_req_out), 32'h4);
        step(7);
        check("por_rel2", 32'(rst_req_out), 32'h0);
        check("por_busy_rel2", 32'(busy), 32'h1);
        step(6);
        check("por_busy_gap2", 32'(busy), 32'h1);
        step(1);
        check("por_run_busy", 32'(busy), 32'h0);
        check("por_run_cause", 32'(rst_cause), 32'h0);

        // Software pulse from RUN
        pulse(1'b1, 1'b0);
        check("sw_out", 32'(rst_req_out), 32'h7);
        check("sw_cause", 32'(rst_cause), 32'h1);
        check("sw_busy", 32'(busy), 32'h1);
        step(8);
        check("sw_hold8", 32'(rst_req_out), 32'h7);
        step(1);
        check("sw_rel0", 32'(rst_req_out), 32'h6);
        step(21);
        check("sw_run_busy", 32'(busy), 32'h0);
        check("sw_run_out", 32'(rst_req_out), 32'h0);

        // Watchdog held 20 cycles
        wdt_rst_req = 1'b1;
        step(20);
        wdt_rst_req = 1'b0;
        check("wdt_held_out", 32'(rst_req_out), 32'h7);
        check("wdt_cause", 32'(rst_cause), 32'h2);
        step(8);
        check("wdt_hold8", 32'(rst_req_out), 32'h7);
        step(1);
        check("wdt_rel0", 32'(rst_req_out), 32'h6);
        step(21);
        check("wdt_run_busy", 32'(busy), 32'h0);

        // Abort from GAP(0)
        pulse(1'b1, 1'b0);
        step(13);
        check("abort_pre_out", 32'(rst_req_out), 32'h6);
        pulse(1'b1, 1'b0);
        check("abort_out", 32'(rst_req_out), 32'h7);
        step(8);
        check("abort_hold8", 32'(rst_req_out), 32'h7);
        step(1);
        check("abort_rel0", 32'(rst_req_out), 32'h6);
        step(21);
        check("abort_run_busy", 32'(busy), 32'h0);

        // Simultaneous sw and wdt
        pulse(1'b1, 1'b1);
        check("both_cause", 32'(rst_cause), 32'h2);
        check("both_out", 32'(rst_req_out), 32'h7);
        step(30);
        check("both_run_busy", 32'(busy), 32'h0);
        check("both_run_out", 32'(rst_req_out), 32'h0);

        // Domain 1 never acknowledges
        stuck = 3'b010;
        pulse(1'b1, 1'b0);
        step(16);
        check("stuck_rel1", 32'(rst_req_out), 32'h4);
        step(63);
        check("stuck_pre_to_out", 32'(rst_req_out), 32'h4);
        check("stuck_pre_to_err", 32'(timeout_err), 32'h0);
        step(1);
`ifdef RSTSEQ_ACK_TIMEOUT_EN
        check("stuck_to_err", 32'(timeout_err), 32'h1);
        step(11);
        check("stuck_to_busy", 32'(busy), 32'h0);
        check("stuck_to_out", 32'(rst_req_out), 32'h0);
        check("stuck_err_sticky", 32'(timeout_err), 32'h1);
`else
        check("stuck_no_err", 32'(timeout_err), 32'h0);
        step(11);
        check("stuck_busy", 32'(busy), 32'h1);
        check("stuck_out", 32'(rst_req_out), 32'h4);
`endif

        // Asynchronous reset mid-sequence
        stuck = 3'b000;
        #2;
        rst = 1'b1;
        #1;
        check("async_out", 32'(rst_req_out), 32'h7);
        check("async_busy", 32'(busy), 32'h1);
        check("async_cause", 32'(rst_cause), 32'h0);
        check("async_err", 32'(timeout_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
